// File: rtl/seq_control_unit.sv
// seq_control_unit
//   Multi-cycle control unit of a small 16-bit class CPU. A 3-state FSM
//   (FETCH -> EXEC [-> MEM]) fetches an instruction word from memory,
//   executes it in one cycle, and optionally performs a byte load or store.
//   It owns the halfword program counter and the instruction register.
//
// Ports
//   clk, rst        : clock, asynchronous active-high reset
//   flags           : ALU flags {f1,f0}
//   ctrl_flags      : decoded controls {cond,adi,ipc,wpc,spc,mem_we,mem_re,ldi}
//   reg_o0..reg_o2  : register file read ports (store data, address hi, address lo)
//   alu_out         : ALU result
//   mem_out         : memory read data; mem_ready : transfer complete
//   mem_addr/mem_in : memory byte address / write data
//   mem_req/mem_we  : memory request / write enable
//   inst            : instruction register
//   reg_in/reg_we   : register file write data / enable
//   alu_b           : ALU B operand
//   pc              : halfword program counter; state : FSM state
module seq_control_unit #(
  parameter int DATA_W = 16,
  parameter int IMM_W  = 8,
  parameter int SIMM_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        flags,
  input  logic [7:0]        ctrl_flags,
  input  logic [DATA_W-1:0] reg_o0,
  input  logic [DATA_W-1:0] reg_o1,
  input  logic [DATA_W-1:0] reg_o2,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [DATA_W-1:0] mem_out,
  input  logic              mem_ready,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_in,
  output logic [DATA_W-1:0] inst,
  output logic [DATA_W-1:0] reg_in,
  output logic [DATA_W-1:0] alu_b,
  output logic [DATA_W-2:0] pc,
  output logic              mem_req,
  output logic              mem_we,
  output logic              reg_we,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_MEM   = 2'd2,
    ST_BAD   = 2'd3
  } state_t;

  localparam logic [DATA_W-2:0] PC_ONE = {{(DATA_W-2){1'b0}}, 1'b1};

  state_t            r_state;
  logic [DATA_W-2:0] r_pc;
  logic [DATA_W-1:0] r_inst;

  // Control flag breakout
  logic w_cond, w_adi, w_ipc, w_wpc, w_spc, w_f_mem_we, w_f_mem_re, w_ldi;
  assign {w_cond, w_adi, w_ipc, w_wpc, w_spc, w_f_mem_we, w_f_mem_re, w_ldi} = ctrl_flags;

  logic w_mem_op, w_load;
  assign w_mem_op = w_f_mem_we | w_f_mem_re;
  // A store wins when both directions are requested.
  assign w_load   = w_f_mem_re & ~w_f_mem_we;

  // Branch condition on the 2-bit condition code above the immediate.
  logic [1:0] w_c;
  logic       w_cond_ok;
  assign w_c       = r_inst[IMM_W+1:IMM_W];
  assign w_cond_ok = ~w_cond
                   | ((w_c == 2'd0) &  flags[0])
                   | ((w_c == 2'd1) &  flags[1])
                   | ((w_c == 2'd2) & ~flags[0])
                   | ((w_c == 2'd3) & ~flags[1]);

  // Immediate forms. The PC offset drops imm[0] because pc counts halfwords.
  logic [IMM_W-1:0]  w_imm;
  logic [DATA_W-2:0] w_pc_off;
  logic [DATA_W-1:0] w_imm_sext;
  logic [DATA_W-1:0] w_simm_sext;
  assign w_imm       = r_inst[IMM_W-1:0];
  assign w_pc_off    = {{(DATA_W-IMM_W){w_imm[IMM_W-1]}}, w_imm[IMM_W-1:1]};
  assign w_imm_sext  = {{(DATA_W-IMM_W){w_imm[IMM_W-1]}}, w_imm};
  assign w_simm_sext = {{(DATA_W-SIMM_W){r_inst[SIMM_W-1]}}, r_inst[SIMM_W-1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_FETCH;
      r_pc    <= '0;
      r_inst  <= '0;
    end else begin
      case (r_state)
        ST_FETCH: begin
          if (mem_ready) begin
            r_inst  <= mem_out;
            r_pc    <= r_pc + PC_ONE;
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (w_mem_op) begin
            r_state <= ST_MEM;
          end else begin
            r_state <= ST_FETCH;
            if (w_cond_ok) begin
              if (w_wpc)
                r_pc <= alu_out[DATA_W-1:1];
              else if (w_ipc)
                r_pc <= r_pc + w_pc_off;
            end
          end
        end
        ST_MEM: begin
          if (mem_ready)
            r_state <= ST_FETCH;
        end
        default: r_state <= ST_FETCH;
      endcase
    end
  end

  logic w_in_exec, w_in_mem;
  assign w_in_exec = (r_state == ST_EXEC);
  assign w_in_mem  = (r_state == ST_MEM);

  assign mem_req  = (r_state == ST_FETCH) | w_in_mem;
  assign mem_addr = w_in_mem ? {reg_o1[DATA_W/2-1:0], reg_o2[DATA_W/2-1:0]} : {r_pc, 1'b0};
  assign mem_we   = w_in_mem & w_f_mem_we;
  assign reg_we   = (w_in_exec & ~w_mem_op) | (w_in_mem & w_load & mem_ready);

  // Byte lane selection by address bit 0; narrow words only have the low lane.
  logic [7:0] w_sel_byte;
  generate
    if (DATA_W >= 16) begin : g_two_lanes
      assign w_sel_byte = mem_addr[0] ? mem_out[15:8] : mem_out[7:0];
      always_comb begin
        mem_in = mem_out;
        if (mem_addr[0])
          mem_in[15:8] = reg_o0[7:0];
        else
          mem_in[7:0] = reg_o0[7:0];
      end
    end else begin : g_one_lane
      assign w_sel_byte = mem_out[7:0];
      always_comb begin
        mem_in      = mem_out;
        mem_in[7:0] = reg_o0[7:0];
      end
    end
  endgenerate

  always_comb begin
    reg_in = alu_out;
    if (w_spc)
      reg_in = {r_pc, 1'b0};
    else if (w_ldi)
      reg_in = w_imm_sext;
    else if (w_in_mem && w_load)
      reg_in = {{(DATA_W-8){1'b0}}, w_sel_byte};
  end

  assign alu_b = w_adi ? w_simm_sext : reg_o2;
  assign inst  = r_inst;
  assign pc    = r_pc;
  assign state = r_state;

  // Bits that are intentionally not consumed (upper register halves, alu_out[0]).
  logic w_unused;
  assign w_unused = ^{alu_out[0], reg_o0, reg_o1, reg_o2};

endmodule

// File: doc/seq_control_unit.md
SEQ_CONTROL_UNIT -- requirements
Module: seq_control_unit

Interface
REQ-001 SHALL provide parameter DATA_W, default 16: register, ALU and memory word width (even, >=8).
REQ-002 SHALL provide parameter IMM_W, default 8: immediate field width, inst[IMM_W-1:0].
REQ-003 SHALL provide parameter SIMM_W, default 4: short ALU immediate width, inst[SIMM_W-1:0].
REQ-004 SHALL use one clock; reset is asynchronous and active-high.
REQ-005 SHALL have ports: clk  in  1  clock; rst  in  1  async active-high reset.
REQ-006 SHALL have inputs: flags  2  ALU flags {f1,f0}; ctrl_flags  8  {cond,adi,ipc,wpc,spc,mem_we,mem_re,ldi} MSB..LSB.
REQ-007 SHALL have inputs: reg_o0, reg_o1, reg_o2, alu_out, mem_out, each DATA_W; mem_ready  1  memory transfer complete.
REQ-008 SHALL have outputs: mem_addr, mem_in, inst, reg_in, alu_b, each DATA_W; pc  DATA_W-1  halfword program counter.
REQ-009 SHALL have outputs: mem_req, mem_we, reg_we, each 1; state  2  current FSM state.

Function
REQ-010 FSM states: FETCH=0, EXEC=1, MEM=2; encoding 3 is unreachable and SHALL return to FETCH on the next clock.
REQ-011 FETCH: mem_req=1, mem_addr={pc,1'b0}, mem_we=0, reg_we=0; hold while mem_ready=0.
REQ-012 FETCH with mem_ready=1: inst<=mem_out, pc<=pc+1 (modulo 2^(DATA_W-1)), state<=EXEC.
REQ-013 EXEC lasts exactly one cycle, mem_req=0.
REQ-014 EXEC with mem_re=1 or mem_we=1: state<=MEM, reg_we=0, no PC change; otherwise reg_we=1, state<=FETCH.
REQ-015 Branch in EXEC, taken when cond_ok: cond_ok = ~cond | (c==0&f0) | (c==1&f1) | (c==2&~f0) | (c==3&~f1), where c=inst[IMM_W+1:IMM_W].
REQ-016 Taken branch: wpc=1 -> pc<=alu_out[DATA_W-1:1]; else ipc=1 -> pc<=pc+sext(imm[IMM_W-1:1]) (PC-relative, wraps); wpc has priority; neither set -> pc unchanged.
REQ-017 MEM: mem_req=1, mem_addr={reg_o1[DATA_W/2-1:0], reg_o2[DATA_W/2-1:0]}; hold while mem_ready=0.
REQ-018 MEM store: mem_we=1 while in MEM; mem_in replaces the byte selected by mem_addr[0] (0=low, 1=high) with reg_o0[7:0], other byte(s) from mem_out.
REQ-019 MEM load: reg_we=1 only in the cycle mem_ready=1; reg_in = selected byte of mem_out, zero-extended.
REQ-020 MEM with mem_ready=1: state<=FETCH; no PC change in MEM.
REQ-021 Store with mem_we and mem_re both set SHALL act as store only.
REQ-022 reg_in priority: spc -> {pc,1'b0}; ldi -> sext(imm); load in MEM -> byte; else alu_out.
REQ-023 alu_b = adi ? sext(inst[SIMM_W-1:0]) : reg_o2.
REQ-024 mem_ready in EXEC SHALL be ignored; zero-wait memory (mem_ready=1 on first req cycle) gives FETCH 1 cycle, EXEC 1, MEM 1.
REQ-025 mem_we and reg_we SHALL never be 1 in the same cycle; neither SHALL be 1 in FETCH.

Reset
REQ-026 rst=1 SHALL immediately force state=FETCH, pc=0, inst=0, hence mem_req=1, mem_we=0, reg_we=0, mem_addr=0.
REQ-027 rst asserted mid-MEM or mid-FETCH SHALL abort the transfer with no register write, no PC update, no inst update.
REQ-028 First FETCH after rst deassertion SHALL use address 0.

Verification
REQ-029 Reset then zero-wait fetch of ALU op (ctrl_flags=0) -> inst loaded, pc 0->1, reg_we=1 for exactly one cycle in EXEC, back to FETCH after 2 cycles.
REQ-030 Fetch with mem_ready low 3 cycles -> state stays FETCH 4 cycles, mem_addr stable, inst updated only on ready cycle.
REQ-031 Load, mem_addr=0x1235, mem_out=0xABCD -> reg_in=0x00AB, reg_we=1 only on ready cycle; address 0x1234 -> 0x00CD.
REQ-032 Store, addr 0x0001, reg_o0=0x0077, mem_out=0x1122 -> mem_in=0x7722, mem_we=1 throughout MEM, reg_we=0.
REQ-033 Conditional ipc, c=2, f0=0, imm=0xFC at pc=5 -> pc=3; same with f0=1 -> pc stays 5; wpc with alu_out=0x0040 -> pc=0x20; pc=0x7FFF fetch -> wraps to 0.
REQ-034 rst pulse during MEM load with mem_ready=1 -> no reg_we, state FETCH, pc=0.
